// File: rtl/alu_bist_ctrl.sv
// Exhaustive BIST sweep controller for a 4-op (add/sub/mul/div) ALU with golden-model compare.
// Optional macro BIST_FIRST_FAIL_EN adds a first_fail capture port {valid, op, a, b}.
module alu_bist_ctrl #(
   parameter int WIDTH   = 4,
   parameter int CNT_W   = 16,
   parameter int ALU_LAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [1:0]        alu_op,
   input  logic [WIDTH-1:0]  alu_c,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fault_ind,
   output logic [CNT_W-1:0]  fault_count
`ifdef BIST_FIRST_FAIL_EN
   ,
   output logic [2*WIDTH+2:0] first_fail
`endif
);

   localparam int IW = 2*WIDTH + 2;
   localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [LW-1:0] WAIT_LAST = LW'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic [LW-1:0]    wait_cnt;
   logic             mismatch;
   logic [CNT_W-1:0] fc_nxt;

   function automatic logic [WIDTH-1:0] golden(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] prod;
      prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      case (op)
         2'd0:    golden = a + b;
         2'd1:    golden = a - b;
         2'd2:    golden = prod[WIDTH-1:0];
         default: golden = (b == '0) ? '1 : a / b;
      endcase
   endfunction

   always_comb begin
      mismatch = (alu_c != golden(alu_op, alu_a, alu_b));
      fc_nxt   = fault_count;
      if (mismatch && (fault_count != '1))
         fc_nxt = fault_count + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         wait_cnt    <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fault_ind   <= 1'b0;
         fault_count <= '0;
`ifdef BIST_FIRST_FAIL_EN
         first_fail  <= '0;
`endif
      end else begin
         fault_ind <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  idx         <= '0;
                  alu_op      <= '0;
                  alu_a       <= '0;
                  alu_b       <= '0;
                  fault_count <= '0;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  busy        <= 1'b1;
`ifdef BIST_FIRST_FAIL_EN
                  first_fail  <= '0;
`endif
                  state       <= S_APPLY;
               end
            end
            S_APPLY: begin
               if (ALU_LAT == 0) begin
                  state <= S_CHECK;
               end else begin
                  wait_cnt <= '0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST)
                  state <= S_CHECK;
               else
                  wait_cnt <= wait_cnt + LW'(1);
            end
            S_CHECK: begin
               fault_ind   <= mismatch;
               fault_count <= fc_nxt;
`ifdef BIST_FIRST_FAIL_EN
               // Only the first mismatch of a sweep is kept.
               if (mismatch && !first_fail[2*WIDTH+2])
                  first_fail <= {1'b1, idx};
`endif
               if (idx == '1) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (fc_nxt == '0);
                  state <= S_DONE;
               end else begin
                  idx                     <= idx + IW'(1);
                  {alu_op, alu_a, alu_b}  <= idx + IW'(1);
                  state                   <= S_APPLY;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Directed bench for alu_bist_ctrl: three instances cover the default build,
// a narrow saturating counter, and a two-cycle registered ALU.
module tb_alu_bist_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

   logic [3:0]  a0, b0, c0, a1, b1, c1, a2, b2, c2, c2_r1;
   logic [1:0]  op0, op1, op2;
   logic        busy0, done0, pass0, fi0;
   logic        busy1, done1, pass1, fi1;
   logic        busy2, done2, pass2, fi2;
   logic [15:0] fc0, fc2;
   logic [3:0]  fc1;
`ifdef BIST_FIRST_FAIL_EN
   logic [10:0] ff0, ff1, ff2;
`endif

   int mode = 0;
   int checks = 0;
   int failures = 0;
   int fi0_tot = 0;

   always #5 clk = ~clk;

   function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input int m);
      logic [7:0] p;
      p = {4'd0, a} * {4'd0, b};
      case (op)
         2'd0:    alu_ref = (m == 1) ? (a + b + 4'd1) : (a + b);
         2'd1:    alu_ref = a - b;
         2'd2:    alu_ref = p[3:0];
         default: alu_ref = (b == 4'd0) ? ((m == 2) ? 4'd0 : 4'hF) : (a / b);
      endcase
   endfunction

   always_comb c0 = alu_ref(op0, a0, b0, mode);
   assign c1 = 4'd0;
   always @(posedge clk) begin
      c2_r1 <= alu_ref(op2, a2, b2, 0);
      c2    <= c2_r1;
   end

   always @(posedge clk) if (fi0 === 1'b1) fi0_tot <= fi0_tot + 1;

   alu_bist_ctrl #(.WIDTH(4), .CNT_W(16), .ALU_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .alu_a(a0), .alu_b(b0), .alu_op(op0),
      .alu_c(c0), .busy(busy0), .done(done0), .pass(pass0), .fault_ind(fi0),
      .fault_count(fc0)
`ifdef BIST_FIRST_FAIL_EN
      , .first_fail(ff0)
`endif
   );

   alu_bist_ctrl #(.WIDTH(4), .CNT_W(4), .ALU_LAT(0)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .alu_a(a1), .alu_b(b1), .alu_op(op1),
      .alu_c(c1), .busy(busy1), .done(done1), .pass(pass1), .fault_ind(fi1),
      .fault_count(fc1)
`ifdef BIST_FIRST_FAIL_EN
      , .first_fail(ff1)
`endif
   );

   alu_bist_ctrl #(.WIDTH(4), .CNT_W(16), .ALU_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .alu_a(a2), .alu_b(b2), .alu_op(op2),
      .alu_c(c2), .busy(busy2), .done(done2), .pass(pass2), .fault_ind(fi2),
      .fault_count(fc2)
`ifdef BIST_FIRST_FAIL_EN
      , .first_fail(ff2)
`endif
   );

   function automatic logic done_of(input int sel);
      case (sel)
         0:       done_of = done0;
         1:       done_of = done1;
         default: done_of = done2;
      endcase
   endfunction

   function automatic int fc_of(input int sel);
      case (sel)
         0:       fc_of = int'(fc0);
         1:       fc_of = int'(fc1);
         default: fc_of = int'(fc2);
      endcase
   endfunction

   // Pulse start on one instance, then count edges from the accept edge until done.
   task automatic run_sweep(input int sel, output int cyc, output int fc_acc, output logic done_acc);
      @(negedge clk);
      if (sel == 0) start0 = 1'b1; else if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      fc_acc   = fc_of(sel);
      done_acc = done_of(sel);
      cyc = 0;
      while (cyc < 10000) begin
         @(posedge clk); #1;
         cyc++;
         if (done_of(sel) === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; start0 = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
      checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done0); end
      checks++; if (pass0 !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass0); end
      checks++; if (fi0 !== 1'b0) begin failures++; $display("FAIL reset_fault_ind got=%b exp=0", fi0); end
      checks++; if (fc0 !== 16'd0) begin failures++; $display("FAIL reset_fault_count got=%0d exp=0", fc0); end
      checks++; if ({op0, a0, b0} !== 10'd0) begin failures++; $display("FAIL reset_alu_ops got=%h exp=0", {op0, a0, b0}); end
      checks++; if ({busy1, busy2, done1, done2} !== 4'd0) begin failures++; $display("FAIL reset_other_duts got=%b exp=0000", {busy1, busy2, done1, done2}); end
`ifdef BIST_FIRST_FAIL_EN
      checks++; if (ff0 !== 11'd0) begin failures++; $display("FAIL reset_first_fail got=%h exp=0", ff0); end
`endif
      @(negedge clk);
      rst = 1'b0; start0 = 1'b0;
      repeat (5) @(posedge clk); #1;
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy0); end
   endtask

   task automatic test_correct_alu();
      int cyc, fca, fi_before; logic dacc;
      mode = 0; fi_before = fi0_tot;
      run_sweep(0, cyc, fca, dacc);
      checks++; if (cyc !== 2048) begin failures++; $display("FAIL correct_cycles got=%0d exp=2048", cyc); end
      checks++; if (fc0 !== 16'd0) begin failures++; $display("FAIL correct_count got=%0d exp=0", fc0); end
      checks++; if (pass0 !== 1'b1) begin failures++; $display("FAIL correct_pass got=%b exp=1", pass0); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL correct_busy got=%b exp=0", busy0); end
      checks++; if (fi0_tot - fi_before !== 0) begin failures++; $display("FAIL correct_fault_pulses got=%0d exp=0", fi0_tot - fi_before); end
      repeat (5) @(posedge clk); #1;
      checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL done_held got=%b exp=1", done0); end
   endtask

   task automatic test_add_fault();
      int cyc, fca, fi_before; logic dacc;
      mode = 1; fi_before = fi0_tot;
      run_sweep(0, cyc, fca, dacc);
      checks++; if (dacc !== 1'b0) begin failures++; $display("FAIL restart_clears_done got=%b exp=0", dacc); end
      checks++; if (cyc !== 2048) begin failures++; $display("FAIL add_cycles got=%0d exp=2048", cyc); end
      checks++; if (fc0 !== 16'd256) begin failures++; $display("FAIL add_count got=%0d exp=256", fc0); end
      checks++; if (pass0 !== 1'b0) begin failures++; $display("FAIL add_pass got=%b exp=0", pass0); end
      checks++; if (fi0_tot - fi_before !== 256) begin failures++; $display("FAIL add_fault_pulses got=%0d exp=256", fi0_tot - fi_before); end
`ifdef BIST_FIRST_FAIL_EN
      checks++; if (ff0 !== 11'h400) begin failures++; $display("FAIL add_first_fail got=%h exp=400", ff0); end
`endif
   endtask

   task automatic test_div_zero();
      int cyc, fca, fi_before; logic dacc;
      mode = 2; fi_before = fi0_tot;
      run_sweep(0, cyc, fca, dacc);
      checks++; if (fca !== 0) begin failures++; $display("FAIL restart_clears_count got=%0d exp=0", fca); end
      checks++; if (cyc !== 2048) begin failures++; $display("FAIL div0_cycles got=%0d exp=2048", cyc); end
      checks++; if (fc0 !== 16'd16) begin failures++; $display("FAIL div0_count got=%0d exp=16", fc0); end
      checks++; if (pass0 !== 1'b0) begin failures++; $display("FAIL div0_pass got=%b exp=0", pass0); end
      checks++; if (fi0_tot - fi_before !== 16) begin failures++; $display("FAIL div0_fault_pulses got=%0d exp=16", fi0_tot - fi_before); end
`ifdef BIST_FIRST_FAIL_EN
      checks++; if (ff0 !== 11'h700) begin failures++; $display("FAIL div0_first_fail got=%h exp=700", ff0); end
`endif
   endtask

   task automatic test_saturate();
      int cyc, fca; logic dacc;
      run_sweep(1, cyc, fca, dacc);
      checks++; if (cyc !== 2048) begin failures++; $display("FAIL sat_cycles got=%0d exp=2048", cyc); end
      checks++; if (fc1 !== 4'd15) begin failures++; $display("FAIL sat_count got=%0d exp=15", fc1); end
      checks++; if (pass1 !== 1'b0) begin failures++; $display("FAIL sat_pass got=%b exp=0", pass1); end
      checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL sat_done got=%b exp=1", done1); end
   endtask

   task automatic test_latency();
      int cyc, fca; logic dacc;
      run_sweep(2, cyc, fca, dacc);
      checks++; if (cyc !== 4096) begin failures++; $display("FAIL lat_cycles got=%0d exp=4096", cyc); end
      checks++; if (fc2 !== 16'd0) begin failures++; $display("FAIL lat_count got=%0d exp=0", fc2); end
      checks++; if (pass2 !== 1'b1) begin failures++; $display("FAIL lat_pass got=%b exp=1", pass2); end
`ifdef BIST_FIRST_FAIL_EN
      checks++; if (ff2 !== 11'd0) begin failures++; $display("FAIL lat_first_fail got=%h exp=0", ff2); end
`endif
   endtask

   task automatic test_abort_restart();
      int cyc, fca; logic dacc;
      mode = 0;
      @(negedge clk); start0 = 1'b1;
      @(posedge clk); #1; start0 = 1'b0;
      repeat (200) @(posedge clk); #1;
      checks++; if ({op0, a0, b0} !== 10'h064) begin failures++; $display("FAIL pattern100 got=%h exp=064", {op0, a0, b0}); end
      @(negedge clk); start0 = 1'b1;
      @(posedge clk); #1; start0 = 1'b0;
      checks++; if ({busy0, op0, a0, b0} !== 11'h464) begin failures++; $display("FAIL start_while_busy got=%h exp=464", {busy0, op0, a0, b0}); end
      repeat (399) @(posedge clk); #1;
      checks++; if ({op0, a0, b0} !== 10'h12C) begin failures++; $display("FAIL pattern300 got=%h exp=12c", {op0, a0, b0}); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      checks++; if ({busy0, done0, pass0, fi0} !== 4'd0) begin failures++; $display("FAIL abort_flags got=%b exp=0000", {busy0, done0, pass0, fi0}); end
      checks++; if ({fc0, op0, a0, b0} !== 26'd0) begin failures++; $display("FAIL abort_regs got=%h exp=0", {fc0, op0, a0, b0}); end
      repeat (50) @(posedge clk); #1;
      checks++; if ({busy0, done0} !== 2'b00) begin failures++; $display("FAIL abort_no_done got=%b exp=00", {busy0, done0}); end
      run_sweep(0, cyc, fca, dacc);
      checks++; if (cyc !== 2048) begin failures++; $display("FAIL rerun_cycles got=%0d exp=2048", cyc); end
      checks++; if ({fc0, pass0} !== 17'd1) begin failures++; $display("FAIL rerun_result got=%h exp=1", {fc0, pass0}); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_correct_alu();
      test_add_fault();
      test_div_zero();
      test_saturate();
      test_latency();
      test_abort_restart();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
On-chip built-in self-test controller for a WIDTH-bit 4-operation ALU (Add/Sub/Mul/Div, 2-bit op code).
- On `start`, sweeps every (op, A, B) combination exhaustively and drives it into the ALU under test.
- Compares each ALU result against an internal golden model, raises a per-pattern fault indicator, and accumulates a saturating fault counter.
- Sits beside the ALU in the DFT wrapper; replaces hand-written directed checks with a hardware sweep.

Parameters:
- WIDTH, 4, ALU operand/result width in bits (2..8).
- CNT_W, 16, width of the fault counter.
- ALU_LAT, 0, ALU result latency in clock cycles (0 = combinational ALU).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle pulse; begins a sweep when idle
- alu_a  output  WIDTH  operand A to ALU
- alu_b  output  WIDTH  operand B to ALU
- alu_op  output  2  op code to ALU: 00 Add, 01 Sub, 10 Mul, 11 Div
- alu_c  input  WIDTH  ALU result
- busy  output  1  sweep in progress
- done  output  1  sweep finished; held until next start or rst
- pass  output  1  valid with done: 1 when fault_count == 0
- fault_ind  output  1  1 for one cycle when the pattern just checked mismatched
- fault_count  output  CNT_W  number of mismatching patterns, saturating

Behaviour:
- Reset (clk edge with rst=1): state IDLE; all outputs 0; pattern index idx = 0. Reset mid-sweep aborts immediately; done stays 0.
- idx width: 2*WIDTH+2 bits, packed {op, a, b}. b is least significant, so b increments fastest, then a, then op.
  - alu_op/alu_a/alu_b are registered copies of the idx fields.
  - alu_op/alu_a/alu_b change only on entry to APPLY.
- FSM states:
  - IDLE: start=1 -> clear fault_count, done, pass; idx=0; load outputs; go to APPLY; busy=1.
  - APPLY: one cycle. If ALU_LAT=0, go to CHECK; else go to WAIT.
  - WAIT: stays ALU_LAT cycles, then goes to CHECK.
  - CHECK: sample alu_c and compare with the expected value.
    - On mismatch: fault_ind=1 next cycle; fault_count+1, holding at all-ones.
    - If idx is all-ones: go to DONE.
    - Otherwise: idx+1, load outputs, go to APPLY.
  - DONE: busy=0, done=1, pass=(fault_count==0). start=1 restarts the sweep as from IDLE.
- Timing: one pattern takes ALU_LAT+2 cycles. A full sweep is 2^(2*WIDTH+2)*(ALU_LAT+2) cycles from the start-accept edge to done rising.
- Golden model (all results truncated to WIDTH bits, unsigned):
  - Add: (A+B) mod 2^WIDTH.
  - Sub: (A-B) mod 2^WIDTH, two's-complement wrap.
  - Mul: low WIDTH bits of A*B.
  - Div: floor(A/B); B=0 gives all-ones.
- start while busy: ignored.
- start and rst in the same cycle: rst wins.
- fault_ind is a registered pulse. It is 0 in every cycle that does not immediately follow a mismatching CHECK.

Optional Feature:
Macro BIST_FIRST_FAIL_EN.
- Defined:
  - Extra output port first_fail, width 2*WIDTH+3: {valid, op, a, b}.
  - Captures the idx of the first mismatching pattern in a sweep and sets valid.
  - Later mismatches do not overwrite it.
  - Cleared by rst and on start accept.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan:
1. Correct behavioural ALU, WIDTH=4, ALU_LAT=0, start pulse -> done rises 2048 cycles after start accept; fault_count=0; pass=1; fault_ind never asserted.
2. ALU returns A+B+1 for Add only -> fault_count=256, pass=0, fault_ind pulses 256 times. With BIST_FIRST_FAIL_EN, first_fail = {1, 00, 0000, 0000}.
3. ALU returns 0 on divide-by-zero, otherwise correct -> fault_count=16 (B=0, all 16 A values). With BIST_FIRST_FAIL_EN, first_fail = {1, 11, 0000, 0000}.
4. CNT_W=4, ALU output stuck at 0 -> fault_count saturates at 15 and stays there; pass=0; done still asserted at the correct cycle.
5. ALU_LAT=2 with a registered ALU model -> 1024*4 = 4096 cycles to done; fault_count=0.
6. rst asserted at pattern 300, then start again -> all outputs 0 after reset, no done pulse from the aborted run; second run completes with fault_count=0. A start pulse issued mid-sweep does not restart or alter the sweep.
